// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan sequencer: state encoding,
// channel/sample widths and the layout of the tagged output word.
package adc_scan_pkg;

  localparam int CH_W     = 3;
  localparam int SAMPLE_W = 12;
  localparam int NUM_CH   = 8;
  localparam int OUT_W    = 16;

  // Output word layout: {pad, channel, sample}
  localparam int SAMPLE_LSB = 0;
  localparam int CH_LSB     = 12;
  localparam int PAD_BIT    = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    CONV,
    PUSH
  } state_t;

  function automatic logic [OUT_W-1:0] pack_word(input logic [CH_W-1:0]     ch,
                                                 input logic [SAMPLE_W-1:0] sample);
    logic [OUT_W-1:0] w;
    w                          = '0;
    w[SAMPLE_LSB +: SAMPLE_W]  = sample;
    w[CH_LSB +: CH_W]          = ch;
    w[PAD_BIT]                 = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/adc_scan_next_ch.sv
// Priority encoder: lowest set bit of mask strictly above cur_ch, or the
// lowest set bit overall when from_start is high (start of a scan).
module adc_scan_next_ch
  import adc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  input  logic              from_start,
  output logic [CH_W-1:0]   next_ch,
  output logic              found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    next_ch = '0;
    found   = 1'b0;
    // Walk downward so the lowest qualifying bit is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur_ch)))) begin
        found   = 1'b1;
        next_ch = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic multi-channel scan controller: on each tick converts every enabled
// channel in ascending order and streams {0, ch, sample} words downstream.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int PERIOD = 40000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                adc_start,
  output logic [CH_W-1:0]     adc_channel,
  input  logic                adc_ready,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_last,
  output logic                busy,
  output logic [7:0]          overrun_count
);

  localparam int            TW   = $clog2(PERIOD);
  localparam logic [TW-1:0] TMAX = TW'(PERIOD - 1);

  state_t              state;
  logic [TW-1:0]       tcount;
  logic                timer_run;
  logic                tick;
  logic [NUM_CH-1:0]   scan_mask;

  logic [NUM_CH-1:0]   search_mask;
  logic                search_start;
  logic [CH_W-1:0]     enc_ch;
  logic                enc_found;

  // The edge that first sees enable leaves IDLE with the count still at 0,
  // so the first tick lands PERIOD edges after that one.
  assign timer_run = enable && (state != IDLE);
  assign tick      = timer_run && (tcount == TMAX);

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (reset) begin
      tcount <= '0;
    end else if (!timer_run || (tcount == TMAX)) begin
      tcount <= '0;
    end else begin
      tcount <= tcount + TW'(1);
    end
  end

  // At scan start search the live mask from bit 0; mid-scan search the snapshot above the current channel.
  always_comb begin
    search_start = (state == WAIT_TICK);
    search_mask  = search_start ? ch_mask : scan_mask;
  end

  adc_scan_next_ch u_next_ch (
    .mask       (search_mask),
    .cur_ch     (adc_channel),
    .from_start (search_start),
    .next_ch    (enc_ch),
    .found      (enc_found)
  );

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the datapath registers are reset too, so every output is defined the moment reset asserts.
    if (reset) begin
      state         <= IDLE;
      scan_mask     <= '0;
      adc_start     <= 1'b0;
      adc_channel   <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      busy          <= 1'b0;
      overrun_count <= '0;
    end else begin
      if (tick && (state == CONV || state == PUSH) && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end

      case (state)
        IDLE: begin
          if (enable) state <= WAIT_TICK;
        end

        WAIT_TICK: begin
          if (!enable) begin
            state <= IDLE;
          end else if (tick && enc_found) begin
            scan_mask   <= ch_mask;
            adc_channel <= enc_ch;
            adc_start   <= 1'b1;
            busy        <= 1'b1;
            state       <= CONV;
          end
        end

        // Conversions always run to completion to keep the ADC serial framing intact.
        CONV: begin
          if (adc_ready) begin
            adc_start <= 1'b0;
            out_data  <= pack_word(adc_channel, adc_data);
            out_last  <= !enc_found;
            out_valid <= 1'b1;
            state     <= PUSH;
          end
        end

        PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!out_last) begin
              adc_channel <= enc_ch;
              adc_start   <= 1'b1;
              state       <= CONV;
            end else begin
              busy  <= 1'b0;
              state <= enable ? WAIT_TICK : IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // A presented word must hold until it is accepted.
  property p_stream_hold;
    @(posedge clock) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last));
  endproperty
  a_stream_hold: assert property (p_stream_hold);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with PERIOD=16 and an ADC model that
// answers 40 cycles after start with data 0x100+channel.
module tb_adc_scan_sequencer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [7:0]  ch_mask;
  logic        adc_start;
  logic [2:0]  adc_channel;
  logic        adc_ready;
  logic [11:0] adc_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic [7:0]  overrun_count;

  int          errors = 0;
  int          checks = 0;
  logic [16:0] words[$];
  int          start_count = 0;
  int          tick_count  = 0;

  adc_scan_sequencer #(.PERIOD(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .ch_mask       (ch_mask),
    .adc_start     (adc_start),
    .adc_channel   (adc_channel),
    .adc_ready     (adc_ready),
    .adc_data      (adc_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .overrun_count (overrun_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] exp_word(input int ch, input bit last);
    logic [2:0]  c;
    logic [11:0] s;
    c = 3'(ch);
    s = 12'(12'h100 + ch);
    return {last, 1'b0, c, s};
  endfunction

  // Negedge models: ADC driver, spec period timer, stream capture, start counter.
  initial begin
    bit         pend = 0;
    int         cnt = 0;
    logic [2:0] ch = '0;
    bit         en_prev = 0;
    int         tcnt = 0;
    bit         start_prev = 0;
    adc_ready = 1'b0;
    adc_data  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend = 0; adc_ready = 1'b0;
        en_prev = 0; tcnt = 0; start_prev = 0;
      end else begin
        if (adc_ready) adc_ready = 1'b0;
        else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            adc_ready = 1'b1;
            adc_data  = 12'(12'h100 + int'(ch));
            pend      = 0;
          end
        end else if (adc_start) begin
          pend = 1; cnt = 40; ch = adc_channel;
        end

        if (!enable) begin
          en_prev = 0; tcnt = 0;
        end else if (!en_prev) begin
          en_prev = 1; tcnt = 0;
        end else if (tcnt == 15) begin
          tick_count++; tcnt = 0;
        end else tcnt++;

        if (out_valid && out_ready) words.push_back({out_last, out_data});
        if (adc_start && !start_prev) start_count++;
        start_prev = adc_start;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_start(input string tag, output int n);
    n = 0;
    while (!adc_start && n < 300) begin
      step(1);
      n++;
    end
    check(tag, adc_start, 1'b1);
  endtask

  task automatic wait_words(input string tag, input int k);
    int n = 0;
    while (words.size() < k && n < 2000) begin
      step(1);
      n++;
    end
    check(tag, 32'(words.size() >= k), 1);
  endtask

  task automatic quiesce();
    int n = 0;
    enable = 1'b0;
    while (busy && n < 1000) begin
      step(1);
      n++;
    end
    check("quiesce_idle", busy, 1'b0);
    step(3);
    words.delete();
  endtask

  initial begin
    int          n;
    int          bad;
    int          o0, t0, sc;
    logic [15:0] d0;
    logic        l0;

    reset = 1'b1; enable = 1'b0; ch_mask = '0; out_ready = 1'b0;
    step(3);
    check("rst_outputs", {adc_start, adc_channel, out_valid, out_data, out_last, busy, overrun_count}, 0);
    reset = 1'b0;
    step(2);

    // Mask 0x05: first start 17 cycles after enable, words ch0 then ch2.
    ch_mask = 8'h05; out_ready = 1'b1; enable = 1'b1;
    wait_start("t1_start_seen", n);
    check("t1_start_latency", n, 17);
    check("t1_first_channel", adc_channel, 3'd0);
    wait_words("t1_words_seen", 2);
    check("t1_busy_after_last", busy, 1'b0);
    check("t1_valid_after_last", out_valid, 1'b0);
    check("t1_word0", words[0], {1'b0, 16'h0100});
    check("t1_word1", words[1], {1'b1, 16'h2102});
    quiesce();

    // Single channel 7: one last word per scan.
    ch_mask = 8'h80; enable = 1'b1;
    wait_start("t2_start_seen", n);
    check("t2_channel", adc_channel, 3'd7);
    wait_words("t2_words_seen", 2);
    check("t2_word0", words[0], {1'b1, 16'h7107});
    check("t2_word1", words[1], {1'b1, 16'h7107});
    quiesce();

    // All channels with downstream stalled: held word and overrun counting.
    ch_mask = 8'hFF; out_ready = 1'b0; enable = 1'b1;
    n = 0;
    while (!out_valid && n < 300) begin
      step(1);
      n++;
    end
    check("t3_valid_seen", out_valid, 1'b1);
    d0 = out_data; l0 = out_last;
    o0 = int'(overrun_count); t0 = tick_count;
    check("t3_held_word", {l0, d0}, {1'b0, 16'h0100});
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!out_valid || out_data !== d0 || out_last !== l0) bad++;
    end
    check("t3_stall_stable", bad, 0);
    check("t3_overrun_delta", int'(overrun_count) - o0, tick_count - t0);
    check("t3_overrun_min6", 32'((int'(overrun_count) - o0) >= 6), 1);
    step(4100);
    check("t3_overrun_sat", overrun_count, 8'd255);
    out_ready = 1'b1;
    wait_words("t3_words_seen", 8);
    for (int c = 0; c < 8; c++) check($sformatf("t3_word%0d", c), words[c], exp_word(c, c == 7));
    check("t3_overrun_hold", overrun_count, 8'd255);
    quiesce();

    // Mask change mid-scan only affects the following scan.
    ch_mask = 8'h03; enable = 1'b1;
    wait_start("t4_start_seen", n);
    ch_mask = 8'h0C;
    wait_words("t4_words_seen", 4);
    check("t4_word0", words[0], exp_word(0, 0));
    check("t4_word1", words[1], exp_word(1, 1));
    check("t4_word2", words[2], exp_word(2, 0));
    check("t4_word3", words[3], exp_word(3, 1));
    quiesce();

    // Enable dropped during conversion of ch1: scan still completes.
    ch_mask = 8'h07; enable = 1'b1;
    n = 0;
    while (!(adc_start && adc_channel == 3'd1) && n < 500) begin
      step(1);
      n++;
    end
    check("t5_conv_ch1_seen", 32'(adc_start && adc_channel == 3'd1), 1);
    enable = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      step(1);
      n++;
    end
    check("t5_word_count", words.size(), 3);
    check("t5_word_ch1", words[1], exp_word(1, 0));
    check("t5_word_ch2", words[2], exp_word(2, 1));
    sc = start_count;
    step(100);
    check("t5_no_more_starts", start_count, sc);
    check("t5_idle_busy", busy, 1'b0);
    words.delete();

    // Asynchronous reset while a word is presented, then a fresh scan.
    ch_mask = 8'h01; out_ready = 1'b0; enable = 1'b1;
    n = 0;
    while (!out_valid && n < 300) begin
      step(1);
      n++;
    end
    check("t6_push_seen", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_outputs", {adc_start, adc_channel, out_valid, out_data, out_last, busy, overrun_count}, 0);
    step(2);
    reset = 1'b0; out_ready = 1'b1;
    wait_start("t6_restart_seen", n);
    check("t6_restart_latency", n, 17);
    check("t6_overrun_cleared", overrun_count, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
